// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sequencing controller.
//   state_t        : controller FSM encoding (IDLE/LOAD/SEND)
//   LETTER_PATTERN : LSB-first mark/space pattern per letter A..H
//   LETTER_LEN     : number of symbol periods per letter pattern
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // 1 = mark, 0 = space; dot = 1, dash = 111, intra-letter gap = 0.
  localparam logic [15:0] LETTER_PATTERN [0:7] = '{
    16'h001D,  // A
    16'h0157,  // B
    16'h05D7,  // C
    16'h0057,  // D
    16'h0001,  // E
    16'h0175,  // F
    16'h0177,  // G
    16'h0055   // H
  };

  localparam logic [3:0] LETTER_LEN [0:7] = '{
    4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
  };

endpackage

// File: rtl/morse_tick_divider.sv
// Symbol-period divider.
//   clock, reset : system clock, async active-high reset
//   clear        : forces the count back to 0
//   tick         : high while the count sits at TICK_CYCLES-1
module morse_tick_divider #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          cnt <= '0;
    else if (clear)     cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/morse_controller.sv
// Sequencer driving a 16-bit Morse shift register: loads the selected
// letter pattern, then issues one zero-fill right shift per symbol period.
// Between shifts the register is held by reloading its own output.
//   clock, reset     : system clock, async active-high reset
//   start            : level request, rising edge starts a transmission
//   letter           : letter select 0..7 = A..H, captured on accept
//   sr_q             : shift register output (feedback)
//   sr_data          : shift register parallel data
//   sr_loadn         : 0 = load sr_data, 1 = shift
//   sr_rotate_right  : shift direction
//   sr_lsright       : zero-fill MSB on right shift
//   morse_out        : current Morse bit
//   busy             : high in LOAD and SEND
//   done             : one-cycle pulse in the final SEND cycle
module morse_controller
  import morse_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  letter,
  input  logic [15:0] sr_q,
  output logic [15:0] sr_data,
  output logic        sr_loadn,
  output logic        sr_rotate_right,
  output logic        sr_lsright,
  output logic        morse_out,
  output logic        busy,
  output logic        done
);

  state_t      state, state_nx;
  logic        start_d;
  logic        start_rise;
  logic [2:0]  letter_q;
  logic [3:0]  bit_cnt;
  logic        tick;
  logic        div_clear;

  assign start_rise = start & ~start_d;

  // Divider only counts in SEND so every bit starts on a fresh period.
  assign div_clear = (state != ST_SEND);

  morse_tick_divider #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      start_d  <= 1'b0;
      letter_q <= 3'd0;
      bit_cnt  <= 4'd0;
    end else begin
      state   <= state_nx;
      start_d <= start;
      if (state == ST_IDLE && start_rise)
        letter_q <= letter;
      if (state == ST_LOAD)
        bit_cnt <= LETTER_LEN[letter_q];
      else if (state == ST_SEND && tick)
        bit_cnt <= bit_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nx        = state;
    sr_data         = sr_q;
    sr_loadn        = 1'b0;
    sr_rotate_right = 1'b0;
    sr_lsright      = 1'b0;
    morse_out       = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        sr_data  = LETTER_PATTERN[letter_q];
        state_nx = ST_SEND;
      end
      ST_SEND: begin
        busy      = 1'b1;
        morse_out = sr_q[0];
        if (tick) begin
          sr_loadn        = 1'b1;
          sr_rotate_right = 1'b1;
          sr_lsright      = 1'b1;
          // Last bit's period has elapsed: this shift empties the pattern.
          if (bit_cnt == 4'd1) begin
            done     = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_controller.sv
// Bench for morse_controller with a behavioural shift register closing the
// sr_q loop. Expected outputs come from a timeline model: cycle t after the
// accepting edge is LOAD for t=0, then bit (t-1)/T with phase (t-1)%T.
module tb_morse_controller;

  localparam int T = 4;

  localparam logic [15:0] PAT [0:7] = '{
    16'h001D, 16'h0157, 16'h05D7, 16'h0057,
    16'h0001, 16'h0175, 16'h0177, 16'h0055
  };
  localparam int LEN [0:7] = '{5, 9, 11, 7, 1, 9, 9, 7};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b1;
  logic [2:0]  letter = 3'd0;
  logic [15:0] sr_q;
  logic [15:0] sr_data;
  logic        sr_loadn, sr_rotate_right, sr_lsright;
  logic        morse_out, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  morse_controller #(.TICK_CYCLES(T)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .letter          (letter),
    .sr_q            (sr_q),
    .sr_data         (sr_data),
    .sr_loadn        (sr_loadn),
    .sr_rotate_right (sr_rotate_right),
    .sr_lsright      (sr_lsright),
    .morse_out       (morse_out),
    .busy            (busy),
    .done            (done)
  );

  // Shift register: parallel load, rotate/logical shift right, rotate left.
  always @(posedge clock or posedge reset) begin
    if (reset)                sr_q <= 16'h0000;
    else if (!sr_loadn)       sr_q <= sr_data;
    else if (sr_rotate_right) sr_q <= sr_lsright ? {1'b0, sr_q[15:1]} : {sr_q[0], sr_q[15:1]};
    else                      sr_q <= {sr_q[14:0], sr_q[15]};
  end

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Timeline model.
  logic        m_act;
  int          m_t;
  int          m_len;
  logic [15:0] m_pat;
  logic        m_sd;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0; m_t <= 0; m_len <= 0; m_pat <= 16'h0; m_sd <= 1'b0;
    end else begin
      m_sd <= start;
      if (m_act) begin
        if (m_t == m_len * T) m_act <= 1'b0;
        else                  m_t <= m_t + 1;
      end else if (start && !m_sd) begin
        m_act <= 1'b1;
        m_t   <= 0;
        m_pat <= PAT[letter];
        m_len <= LEN[letter];
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    logic [15:0] eq, ed;
    logic        eb, em, el, edn;
    int          k, ph;
    eq = 16'h0; ed = 16'h0; eb = 1'b0; em = 1'b0; el = 1'b0; edn = 1'b0;
    if (m_act) begin
      eb = 1'b1;
      if (m_t == 0) begin
        ed = m_pat;
      end else begin
        k   = (m_t - 1) / T;
        ph  = (m_t - 1) % T;
        eq  = m_pat >> k;
        em  = eq[0];
        el  = (ph == T - 1);
        edn = (m_t == m_len * T);
        ed  = eq;
      end
    end
    chk("busy", 16'(busy), 16'(eb));
    chk("done", 16'(done), 16'(edn));
    chk("morse_out", 16'(morse_out), 16'(em));
    chk("sr_loadn", 16'(sr_loadn), 16'(el));
    chk("sr_rotate_right", 16'(sr_rotate_right), 16'(el));
    chk("sr_lsright", 16'(sr_lsright), 16'(el));
    chk("sr_q", sr_q, eq);
    if (!el) chk("sr_data", sr_data, ed);
  end

  // Transmission monitor: busy length, per-cycle morse capture, shift count.
  int   blen = 0, shifts = 0, last_len = 0;
  logic cap [0:63];

  always @(negedge clock) begin
    if (busy) begin
      if (blen < 64) cap[blen] = morse_out;
      blen = blen + 1;
      if (sr_loadn) shifts = shifts + 1;
      if (done) begin
        last_len = blen;
        chk("shift_count", 16'(shifts), 16'(m_len));
      end
    end else begin
      blen   = 0;
      shifts = 0;
    end
  end

  task automatic wait_done(input string n);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) break;
    end
    #1;
    if (i == 200) begin
      total++; bad++;
      $display("FAIL %s: done timeout, got none expected pulse", n);
    end
  endtask

  // Literal expectations: busy length and the morse bit sampled mid-period.
  task automatic check_tx(input string n, input int exp_len, input logic [15:0] bits, input int nb);
    chk({n, "_busy_len"}, 16'(last_len), 16'(exp_len));
    for (int i = 0; i < nb; i++)
      chk({n, "_bit"}, 16'(cap[1 + T*i + 1]), 16'(bits[i]));
  endtask

  task automatic pulse_start(input logic [2:0] l);
    @(negedge clock);
    letter = l;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  initial begin
    // Reset with start held high.
    repeat (3) begin
      @(negedge clock);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_loadn", 16'(sr_loadn), 16'h0);
      chk("rst_morse", 16'(morse_out), 16'h0);
    end
    reset = 1'b0;
    wait_done("A_after_reset");
    check_tx("A_after_reset", 21, 16'b11101, 5);
    repeat (6) begin
      @(negedge clock);
      chk("no_retrigger", 16'(busy), 16'h0);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);

    // Letter A, plain.
    pulse_start(3'd0);
    wait_done("A");
    check_tx("A", 21, 16'b11101, 5);
    repeat (3) @(negedge clock);

    // Letter A with start toggles and letter change during SEND.
    pulse_start(3'd0);
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; letter = 3'd7;
    wait_done("A_ignored");
    check_tx("A_ignored", 21, 16'b11101, 5);
    repeat (3) @(negedge clock);

    // E, then C started the cycle after done.
    pulse_start(3'd4);
    wait_done("E");
    check_tx("E", 5, 16'b1, 1);
    letter = 3'd2;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("C");
    check_tx("C", 45, 16'h05D7, 11);
    repeat (3) @(negedge clock);

    // Reset during bit 2 of C.
    pulse_start(3'd2);
    repeat (9) @(negedge clock);
    chk("C_bit2_before_reset", 16'(morse_out), 16'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_morse", 16'(morse_out), 16'h0);
    chk("midrst_done", 16'(done), 16'h0);
    chk("midrst_sr_q", sr_q, 16'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pulse_start(3'd4);
    wait_done("E_after_reset");
    check_tx("E_after_reset", 5, 16'b1, 1);
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_controller.md
# morse_controller

Sequencing controller that sits directly upstream of the 16-bit Morse shift register. It selects a letter's Morse bit pattern, parallel-loads it, and paces one bit per symbol period by issuing right-shifts with zero fill. Between shifts it holds the register by reloading the register's own output, so the register can run on the system clock. It also presents the current Morse bit and busy/done status to the top level.

## Interface
- TICK_CYCLES, 25_000_000, clock cycles per Morse symbol (0.5 s at 50 MHz). Legal range ≥ 2.
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level request; its rising edge, detected internally, starts a transmission.
- letter  in  3  letter select, 0..7 = A..H; captured when the start edge is accepted.
- sr_q  in  16  Q_out fed back from the shift register.
- sr_data  out  16  DATA_IN driven to the shift register.
- sr_loadn  out  1  ParallelLoadn; 0 = load sr_data, 1 = shift.
- sr_rotate_right  out  1  RotateRight.
- sr_lsright  out  1  LSRight; 1 = zero-fill the MSB.
- morse_out  out  1  current Morse bit (LED drive).
- busy  out  1  high while the block is in LOAD or SEND.
- done  out  1  one-cycle pulse when a transmission completes.

## Operation
- Patterns are transmitted LSB-first. 1 = mark, 0 = space. A dot is 1, a dash is 111, and the intra-letter gap is 0.
- Pattern and length per letter:
  - A 0x001D / 5
  - B 0x0157 / 9
  - C 0x05D7 / 11
  - D 0x0057 / 7
  - E 0x0001 / 1
  - F 0x0175 / 9
  - G 0x0177 / 9
  - H 0x0055 / 7
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - Drives sr_loadn=0 and sr_data=sr_q (hold).
  - morse_out=0, busy=0.
  - A start rising edge latches letter into letter_q and moves to LOAD.
- LOAD (exactly 1 cycle):
  - Drives sr_data=pattern(letter_q) and sr_loadn=0.
  - Sets bit_cnt=len(letter_q) and clears the tick counter.
  - Moves to SEND.
- SEND:
  - morse_out = sr_q[0]; busy=1.
  - The tick counter runs from 0 to TICK_CYCLES-1.
  - On non-terminal cycles: hold (sr_loadn=0, sr_data=sr_q).
  - On the terminal count: shift (sr_loadn=1, sr_rotate_right=1, sr_lsright=1), counter wraps to 0, and bit_cnt decrements.
  - If bit_cnt==1 on a terminal count, the block returns to IDLE and pulses done in the same cycle.
- sr_rotate_right and sr_lsright are 0 whenever sr_loadn=0.
- Start edges arriving in LOAD or SEND are ignored. Changes on letter outside the accept cycle are ignored.
- Edge detection uses a start_d register that resets to 0. A start held high through reset release therefore triggers exactly one transmission.
- Width rules:
  - bit_cnt is 4 bits (maximum length 11).
  - The tick counter is $clog2(TICK_CYCLES) bits and never exceeds TICK_CYCLES-1.

## Timing
- Reset values: state=IDLE, counters=0, letter_q=0, start_d=0.
- Outputs during reset: sr_loadn=0, sr_data=sr_q, sr_rotate_right=0, sr_lsright=0, morse_out=0, busy=0, done=0.
- The shift register shares the same reset, so it is also cleared.
- Transmission timeline, taking edge N as the edge that samples the start rise:
  - The FSM is in LOAD after edge N.
  - The pattern is in sr_q and the FSM is in SEND after edge N+1.
  - morse_out shows bit 0 from N+1 for TICK_CYCLES cycles. Each subsequent bit lasts TICK_CYCLES cycles.
- busy is high for 1 + len×TICK_CYCLES cycles.
- done is high in the final SEND cycle; IDLE is entered at the following edge.
- The earliest accepted next start is the cycle after done. A new start needs a fresh rising edge.
- Reset mid-transmission: every output goes to its reset value immediately (asynchronously). There is no partial completion and no done pulse.
- All outputs except sr_data are decoded from registered state only. sr_data is combinational from state, letter_q and sr_q.

## Structure
- Package morse_pkg holds:
  - state encoding (IDLE/LOAD/SEND);
  - LETTER_PATTERN[0:7] as 16-bit constants;
  - LETTER_LEN[0:7] as 4-bit constants.
- Sub-module morse_tick_divider(clock, reset, clear, tick) contains the TICK_CYCLES counter. tick is high on the terminal count, and clear forces the count to 0.
- The FSM, bit_cnt, letter_q and the start edge detector live in morse_controller.
- The bench instantiates the controller together with the shift register and closes the sr_q loop.

## Test plan
All scenarios use TICK_CYCLES=4.
- **Reset:** assert reset for 3 cycles with start=1, then release → all outputs 0 during reset. Exactly one transmission follows release, because start_d was 0.
- **Letter A:**
  - Stimulus: letter=0, pulse start.
  - morse_out = 1,0,1,1,1, each bit 4 cycles wide.
  - busy is high for 21 cycles; done is a single pulse in the last busy cycle.
  - sr_q ends at 0x0000.
- **Letter E, then C:**
  - E gives one 4-cycle mark.
  - A start issued the cycle after done is accepted and gives morse_out for C = 1,1,1,0,1,0,1,1,1,0,1 (44 cycles).
- **Ignored inputs:** during A's SEND, toggle start twice and change letter to 7 → no restart, and the A sequence completes unchanged.
- **Reset mid-SEND:** assert reset at bit 2 of C → morse_out, busy and done go to 0 immediately. After release, a start with letter=4 produces a clean E.
- **Shift-register controls:** check every cycle that sr_loadn=1 is asserted exactly len times per transmission, each time on a tick-counter value of 3. Check that sr_rotate_right and sr_lsright are never 1 while sr_loadn=0.
